// File: rtl/tdm_pkg.sv
// Shared types and sizing for the 8-to-1 TDM transmit path.
// TDM_MUX_PARITY_EN adds a 9th (even-parity) slot to every frame.
package tdm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tdm_state_e;

   localparam int TDM_LANES = 8;
   localparam int TDM_SEL_W = 3;

`ifdef TDM_MUX_PARITY_EN
   // Slots 0..7 carry data, slot 8 carries parity.
   localparam int TDM_CNT_W     = 4;
   localparam int TDM_LAST_SLOT = 8;
`else
   localparam int TDM_CNT_W     = 3;
   localparam int TDM_LAST_SLOT = 7;
`endif

   localparam int TDM_FRAME_LEN = TDM_LAST_SLOT + 1;

endpackage

// File: rtl/tdm_mux_8to1_if.sv
// Parallel-in / serial-out bus of the TDM multiplexer.
// Handshake: a word moves when in_valid && in_ready on a rising clk edge;
// in_valid may be asserted without waiting for in_ready, in is ignored otherwise.
interface tdm_mux_8to1_if;
   import tdm_pkg::*;

   logic [TDM_LANES-1:0] in;
   logic                 in_valid;
   logic                 in_ready;
   logic                 out;
   logic [TDM_SEL_W-1:0] sel;
   logic                 out_valid;
   logic                 frame_start;
   logic                 busy;

   modport master (
      output in, in_valid,
      input  in_ready, out, sel, out_valid, frame_start, busy
   );

   modport slave (
      input  in, in_valid,
      output in_ready, out, sel, out_valid, frame_start, busy
   );

endinterface

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter: clear forces slot 0, advance steps 0..LAST and wraps.
// cnt_next is the slot that becomes current after the next edge.
module tdm_slot_counter #(
   parameter int WIDTH = 3,
   parameter int LAST  = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   output logic [WIDTH-1:0] cnt_next,
   output logic             last
);

   localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

   logic [WIDTH-1:0] cnt;

   assign last = (cnt == LAST_V);

   always_comb begin
      cnt_next = cnt;
      if (clear) begin
         cnt_next = '0;
      end else if (advance) begin
         cnt_next = last ? '0 : cnt + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/tdm_mux_8to1.sv
// 8-to-1 time-division multiplexer: latches a word, shifts it out one bit per
// slot with the slot index on sel. TDM_MUX_PARITY_EN appends an even-parity slot.
module tdm_mux_8to1
   import tdm_pkg::*;
#(
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   tdm_mux_8to1_if.slave        bus,
   output tdm_state_e           state_dbg
);

   tdm_state_e           state;
   logic [TDM_LANES-1:0] data;
   logic [TDM_CNT_W-1:0] cnt_next;
   logic                 last;
   logic                 xfer;
   logic                 slot_bit;
   logic [TDM_SEL_W-1:0] slot_sel;

   assign state_dbg = state;

   // Ready in IDLE and in the final slot so frames can chain without a gap.
   assign bus.in_ready = !rst && ((state == IDLE) || last);
   assign xfer         = bus.in_valid && bus.in_ready;

   tdm_slot_counter #(
      .WIDTH (TDM_CNT_W),
      .LAST  (TDM_LAST_SLOT)
   ) u_slot_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (state == IDLE),
      .advance  (state == SEND),
      .cnt_next (cnt_next),
      .last     (last)
   );

   // Bit and index for the slot that follows the next edge within the held word.
`ifdef TDM_MUX_PARITY_EN
   always_comb begin
      if (cnt_next == TDM_CNT_W'(TDM_LAST_SLOT)) begin
         slot_bit = ^data;
         slot_sel = TDM_SEL_W'(TDM_LANES - 1);
      end else begin
         slot_bit = data[cnt_next[TDM_SEL_W-1:0]];
         slot_sel = cnt_next[TDM_SEL_W-1:0];
      end
   end
`else
   always_comb begin
      slot_bit = data[cnt_next[TDM_SEL_W-1:0]];
      slot_sel = cnt_next[TDM_SEL_W-1:0];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         data            <= '0;
         bus.out         <= IDLE_LEVEL;
         bus.sel         <= '0;
         bus.out_valid   <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.busy        <= 1'b0;
      end else if (xfer) begin
         // New word: slot 0 of it is visible right after this edge.
         state           <= SEND;
         data            <= bus.in;
         bus.out         <= bus.in[0];
         bus.sel         <= '0;
         bus.out_valid   <= 1'b1;
         bus.frame_start <= 1'b1;
         bus.busy        <= 1'b1;
      end else if ((state == SEND) && last) begin
         state           <= IDLE;
         bus.out         <= IDLE_LEVEL;
         bus.sel         <= '0;
         bus.out_valid   <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.busy        <= 1'b0;
      end else if (state == SEND) begin
         bus.out         <= slot_bit;
         bus.sel         <= slot_sel;
         bus.out_valid   <= 1'b1;
         bus.frame_start <= 1'b0;
         bus.busy        <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Directed bench for tdm_mux_8to1; also covers the parity slot when
// TDM_MUX_PARITY_EN is defined.
module tb_tdm_mux_8to1;
   import tdm_pkg::*;

   localparam logic IDLE_LEVEL = 1'b1;
   localparam int   FRAME_LEN  = TDM_FRAME_LEN;

   logic       clk = 1'b0;
   logic       rst;
   tdm_state_e state_dbg;

   tdm_mux_8to1_if bus ();

   tdm_mux_8to1 #(.IDLE_LEVEL(IDLE_LEVEL)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];

   logic       cap_out   [32];
   logic [2:0] cap_sel   [32];
   logic       cap_valid [32];
   logic       cap_fs    [32];
   logic       cap_rdy   [32];
   logic       cap_busy  [32];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         cap_out[base+i]   = bus.out;
         cap_sel[base+i]   = bus.sel;
         cap_valid[base+i] = bus.out_valid;
         cap_fs[base+i]    = bus.frame_start;
         cap_rdy[base+i]   = bus.in_ready;
         cap_busy[base+i]  = bus.busy;
         tick();
      end
   endtask

   task automatic send_word(input logic [7:0] w);
      bus.in       = w;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.in       = 8'h00;
      bus.in_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready_during_rst: got %b expected 0", bus.in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.sel, bus.out, bus.frame_start, bus.busy} !==
          {1'b1, 1'b0, 3'd0, IDLE_LEVEL, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b sel=%0d out=%b fs=%b busy=%b expected rdy=1 vld=0 sel=0 out=%b fs=0 busy=0",
                  bus.in_ready, bus.out_valid, bus.sel, bus.out, bus.frame_start, bus.busy, IDLE_LEVEL);
      end
      checks++;
      if (state_dbg !== IDLE) begin
         failures++; $display("FAIL reset_state: got %0d expected IDLE", state_dbg);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({bus.out_valid, bus.out, bus.busy, bus.in_ready, state_dbg} !==
          {1'b0, IDLE_LEVEL, 1'b0, 1'b1, IDLE}) begin
         failures++;
         $display("FAIL %s_idle: got vld=%b out=%b busy=%b rdy=%b state=%0d expected vld=0 out=%b busy=0 rdy=1 state=IDLE",
                  name, bus.out_valid, bus.out, bus.busy, bus.in_ready, state_dbg, IDLE_LEVEL);
      end
   endtask

   task automatic test_single();
      logic [7:0] exp_bits = 8'b1010_0101;   // slots 0..7 = 1,0,1,0,0,1,0,1
      logic [7:0] got, exp;
      send_word(8'hA5);
      capture(0, FRAME_LEN);
      for (int s = 0; s < 8; s++) begin
         got = {cap_out[s], cap_sel[s], cap_valid[s], cap_fs[s], cap_rdy[s], cap_busy[s]};
         exp = {exp_bits[s], 3'(s), 1'b1, (s == 0), (s == FRAME_LEN - 1), 1'b1};
         checks++;
         if (got !== exp) begin
            failures++; $display("FAIL single_a5_slot%0d: got {out,sel,vld,fs,rdy,busy}=%b expected %b", s, got, exp);
         end
      end
      check_idle("single_a5");
   endtask

   task automatic test_back_to_back();
      logic [5:0] got, exp;
      int slot;
      bus.in       = 8'hFF;
      bus.in_valid = 1'b1;
      tick();
      bus.in = 8'h00;
      capture(0, FRAME_LEN);
      bus.in_valid = 1'b0;
      capture(FRAME_LEN, FRAME_LEN);
      for (int i = 0; i < 2 * FRAME_LEN; i++) begin
         slot = i % FRAME_LEN;
         if (slot < 8) begin
            got = {cap_out[i], cap_sel[i], cap_valid[i], cap_fs[i]};
            exp = {(i < FRAME_LEN), 3'(slot), 1'b1, (slot == 0)};
            checks++;
            if (got !== exp) begin
               failures++; $display("FAIL b2b_cycle%0d: got {out,sel,vld,fs}=%b expected %b", i, got, exp);
            end
         end
      end
      check_idle("b2b");
   endtask

   task automatic test_hold_input();
      logic [7:0] exp_bits = 8'b0011_1100;   // slots 0..7 = 0,0,1,1,1,1,0,0
      bus.in       = 8'h3C;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in       = 8'h00;
      capture(0, 3);
      bus.in_valid = 1'b1;            // offered while not ready: must be ignored
      capture(3, 1);
      bus.in_valid = 1'b0;
      capture(4, FRAME_LEN - 4);
      for (int s = 0; s < 8; s++) begin
         checks++;
         if ({cap_out[s], cap_rdy[s]} !== {exp_bits[s], (s == FRAME_LEN - 1)}) begin
            failures++;
            $display("FAIL hold_3c_slot%0d: got out=%b rdy=%b expected out=%b rdy=%b",
                     s, cap_out[s], cap_rdy[s], exp_bits[s], (s == FRAME_LEN - 1));
         end
      end
      check_idle("hold_3c");
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_bits = 8'b0000_1111;   // slots 0..7 = 1,1,1,1,0,0,0,0
      send_word(8'hF0);
      repeat (4) tick();
      checks++;
      if ({bus.sel, bus.out} !== {3'd4, 1'b1}) begin
         failures++; $display("FAIL rstmid_at_slot4: got sel=%0d out=%b expected sel=4 out=1", bus.sel, bus.out);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.out_valid, bus.sel, bus.busy, bus.frame_start, bus.out, bus.in_ready} !==
          {1'b0, 3'd0, 1'b0, 1'b0, IDLE_LEVEL, 1'b0}) begin
         failures++;
         $display("FAIL rstmid_abort: got vld=%b sel=%0d busy=%b fs=%b out=%b rdy=%b expected vld=0 sel=0 busy=0 fs=0 out=%b rdy=0",
                  bus.out_valid, bus.sel, bus.busy, bus.frame_start, bus.out, bus.in_ready, IDLE_LEVEL);
      end
      rst = 1'b0;
      send_word(8'h0F);
      capture(0, FRAME_LEN);
      for (int s = 0; s < 8; s++) begin
         checks++;
         if ({cap_out[s], cap_sel[s], cap_fs[s]} !== {exp_bits[s], 3'(s), (s == 0)}) begin
            failures++;
            $display("FAIL rstmid_0f_slot%0d: got out=%b sel=%0d fs=%b expected out=%b sel=%0d fs=%b",
                     s, cap_out[s], cap_sel[s], cap_fs[s], exp_bits[s], s, (s == 0));
         end
      end
      check_idle("rstmid_0f");
   endtask

`ifdef TDM_MUX_PARITY_EN
   task automatic test_parity();
      send_word(8'h07);
      capture(0, FRAME_LEN);
      checks++;
      if ({cap_out[8], cap_sel[8], cap_valid[8], cap_fs[8], cap_rdy[8], cap_rdy[7]} !==
          {1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL parity_07: got out=%b sel=%0d vld=%b fs=%b rdy8=%b rdy7=%b expected out=1 sel=7 vld=1 fs=0 rdy8=1 rdy7=0",
                  cap_out[8], cap_sel[8], cap_valid[8], cap_fs[8], cap_rdy[8], cap_rdy[7]);
      end
      check_idle("parity_07");
      send_word(8'h03);
      capture(0, FRAME_LEN);
      checks++;
      if ({cap_out[8], cap_sel[8], cap_valid[8]} !== {1'b0, 3'd7, 1'b1}) begin
         failures++;
         $display("FAIL parity_03: got out=%b sel=%0d vld=%b expected out=0 sel=7 vld=1",
                  cap_out[8], cap_sel[8], cap_valid[8]);
      end
      check_idle("parity_03");
   endtask
`endif

   task automatic test_sweep();
      int         w = 0, idx = 0, frames_done = 0, gaps = 0;
      logic       started = 1'b0;
      logic       xfer;
      logic [7:0] reasm = 8'h00;
      logic [7:0] e;
      bus.in       = 8'h00;
      bus.in_valid = 1'b1;
      for (int cyc = 0; (cyc < 256 * FRAME_LEN + 40) && (frames_done < 256); cyc++) begin
         if (bus.out_valid) begin
            if (bus.frame_start) begin
               if (started) begin
                  checks++;
                  if (idx !== FRAME_LEN) begin
                     failures++; $display("FAIL sweep_frame_len: got %0d slots expected %0d", idx, FRAME_LEN);
                  end
               end
               started = 1'b1;
               idx     = 0;
            end
            if (idx < 8) reasm[bus.sel] = bus.out;
            if (idx == 7) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++; $display("FAIL sweep_word: got %h with empty expected queue", reasm);
               end else begin
                  e = exp_q.pop_front();
                  if (reasm !== e) begin
                     failures++; $display("FAIL sweep_word: got %h expected %h", reasm, e);
                  end
               end
               frames_done++;
            end
`ifdef TDM_MUX_PARITY_EN
            if (idx == 8) begin
               checks++;
               if ({bus.out, bus.sel} !== {^reasm, 3'd7}) begin
                  failures++; $display("FAIL sweep_parity: got out=%b sel=%0d expected out=%b sel=7", bus.out, bus.sel, ^reasm);
               end
            end
`endif
            idx++;
         end else if (started) begin
            gaps++;
         end
         xfer = bus.in_valid && bus.in_ready;
         if (xfer) exp_q.push_back(bus.in);
         tick();
         if (xfer) begin
            w++;
            if (w == 256) bus.in_valid = 1'b0;
            else          bus.in = 8'(w);
         end
      end
      checks++;
      if (frames_done !== 256) begin
         failures++; $display("FAIL sweep_frames: got %0d expected 256 within cycle budget", frames_done);
      end
      checks++;
      if (gaps !== 0) begin
         failures++; $display("FAIL sweep_gaps: got %0d idle cycles expected 0", gaps);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         failures++; $display("FAIL sweep_leftover: got %0d unsent words expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold_input();
      test_reset_mid();
`ifdef TDM_MUX_PARITY_EN
      test_parity();
`endif
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
